// File: rtl/vga_pkg.sv
// vga_pkg: shared video-timing constants, RAM geometry defaults and the
// blanking-arbiter state type.
package vga_pkg;
    localparam int ACTIVE_LINES = 476;
    localparam int LINE_W       = 9;
    localparam int RAM_AW       = 8;
    localparam int RAM_DW       = 16;

    typedef enum logic {RENDER, GRANT} state_e;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick starting at ptr and wrapping at N;
// reusable for any shared single-port resource.
module rr_arbiter
    import vga_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);
    // Later assignments win: wrapped indices first, then indices at or above ptr,
    // each scanned downward so the lowest index in the higher-priority region wins.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (en && req[i] && PW'(i) < ptr) begin
                gnt      = '0;
                gnt[i]   = 1'b1;
                next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (en && req[i] && PW'(i) >= ptr) begin
                gnt      = '0;
                gnt[i]   = 1'b1;
                next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end
endmodule

// File: rtl/vram_vblank_arbiter.sv
// vram_vblank_arbiter: renderer owns the sprite RAM during active video; game
// masters share it round-robin during vertical blanking, with a per-frame tick.
module vram_vblank_arbiter #(
    parameter int N_REQ        = 4,
    parameter int AW           = vga_pkg::RAM_AW,
    parameter int DW           = vga_pkg::RAM_DW,
    parameter int ACTIVE_LINES = vga_pkg::ACTIVE_LINES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                V_sync,
    input  logic                VGA_enable,
    input  logic [AW-1:0]       ren_addr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    input  logic [DW-1:0]       ram_rdata,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_we,
    output logic [DW-1:0]       ram_wdata,
    output logic                frame_tick,
    output logic                overrun
);
    import vga_pkg::*;

    localparam int PW = ptr_w(N_REQ);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(ACTIVE_LINES - 1);
    localparam logic [LINE_W-1:0] MAX_LINE  = LINE_W'(ACTIVE_LINES);

    state_e            state_q, state_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d, next_ptr;
    logic              vs_q, en_q;
    logic              vs_rise, vs_fall, en_rise, en_fall;
    logic              win_open, win_close, arb_en;
    logic              unused_rdata;

    // Read data goes straight from the RAM to its consumers; only rvalid is ours.
    assign unused_rdata = ^ram_rdata;

    assign en_fall = ~VGA_enable & en_q;
    assign en_rise = VGA_enable & ~en_q;
    assign vs_rise = V_sync & ~vs_q;
    assign vs_fall = ~V_sync & vs_q;

    // vs_fall also opens the window so a frame that lost lines still gets its update.
    assign win_open  = (state_q == RENDER) & ((en_fall & (line_cnt_q == LAST_LINE)) | vs_fall);
    assign win_close = (state_q == GRANT) & (vs_rise | en_rise);
    assign state_d   = win_open ? GRANT : win_close ? RENDER : state_q;

    assign line_cnt_d = vs_rise ? '0
                      : (en_fall && line_cnt_q != MAX_LINE) ? line_cnt_q + 1'b1
                      : line_cnt_q;

    assign arb_en   = (state_q == GRANT) & ~vs_rise & ~VGA_enable;
    assign rr_ptr_d = (|gnt) ? next_ptr : rr_ptr_q;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .en       (arb_en),
        .req      (req),
        .ptr      (rr_ptr_q),
        .gnt      (gnt),
        .next_ptr (next_ptr)
    );

    always_comb begin
        ram_addr  = ren_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                ram_addr  = req_addr[i*AW +: AW];
                ram_we    = req_we[i];
                ram_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RENDER;
            line_cnt_q <= '0;
            rr_ptr_q   <= '0;
            vs_q       <= 1'b1;
            en_q       <= 1'b0;
            rvalid     <= '0;
            frame_tick <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            vs_q       <= V_sync;
            en_q       <= VGA_enable;
            rvalid     <= gnt & ~req_we;
            frame_tick <= win_open;
            overrun    <= overrun | (win_close & (|req));
        end
    end
endmodule

// File: tb/tb_vram_vblank_arbiter.sv
// tb_vram_vblank_arbiter: scenario tasks plus randomized frames, checked every
// cycle against a frame-level behavioural model of the blanking arbiter.
module tb_vram_vblank_arbiter;
    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int ACT = 476;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            V_sync = 1'b1;
    logic            VGA_enable = 1'b0;
    logic [AW-1:0]   ren_addr = '0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   ram_rdata = '0;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [DW-1:0]   ram_wdata;
    logic            frame_tick, overrun;

    logic [DW-1:0] mem [256] = '{default: '0};
    int nvec = 0, nerr = 0, ticks = 0, gnts = 0, wes = 0;
    bit rnd = 0;

    // Reference model state: window open flag, lines seen, next master in turn.
    bit           m_win = 0, m_vs = 1, m_en = 0, m_tick = 0, m_over = 0;
    int           m_lines = 0, m_next = 0;
    logic [N-1:0] m_rv = '0;

    always #5 clk = ~clk;

    vram_vblank_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ACTIVE_LINES(ACT)) dut (
        .clk(clk), .rst_n(rst_n), .V_sync(V_sync), .VGA_enable(VGA_enable),
        .ren_addr(ren_addr), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .ram_rdata(ram_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .frame_tick(frame_tick), .overrun(overrun)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g = '0;
        bit found = 0;
        int idx;
        if (m_win && !(V_sync && !m_vs) && !VGA_enable) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_next + k) % N;
                if (!found && req[idx]) begin
                    g[idx] = 1'b1;
                    found = 1;
                end
            end
        end
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] g;
        bit vr, vf, er, ef, op, cl;
        if (!rst_n) begin
            m_win <= 0; m_vs <= 1; m_en <= 0; m_tick <= 0; m_over <= 0;
            m_lines <= 0; m_next <= 0; m_rv <= '0;
        end else begin
            g  = model_gnt();
            vr = V_sync && !m_vs;
            vf = !V_sync && m_vs;
            er = VGA_enable && !m_en;
            ef = !VGA_enable && m_en;
            op = !m_win && ((ef && m_lines == ACT - 1) || vf);
            cl = m_win && (vr || er);
            m_tick <= op;
            if (cl && req != '0) m_over <= 1;
            m_rv <= g & ~req_we;
            for (int i = 0; i < N; i++) if (g[i]) m_next <= (i + 1) % N;
            m_lines <= vr ? 0 : (ef && m_lines < ACT) ? m_lines + 1 : m_lines;
            m_win <= op ? 1'b1 : cl ? 1'b0 : m_win;
            m_vs <= V_sync;
            m_en <= VGA_enable;
        end
    end

    task automatic cyc();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ed;
        if (rnd) begin
            ren_addr  = AW'($urandom);
            req       = N'($urandom);
            req_we    = N'($urandom);
            req_addr  = $urandom;
            req_wdata = {$urandom, $urandom};
        end
        #1;
        eg = model_gnt();
        ea = ren_addr; ew = 1'b0; ed = '0;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
                ea = req_addr[i*AW +: AW];
                ew = req_we[i];
                ed = req_wdata[i*DW +: DW];
            end
        end
        nvec += 7;
        if (gnt !== eg) begin nerr++; $display("FAIL gnt t=%0t got %b exp %b", $time, gnt, eg); end
        if (ram_addr !== ea) begin nerr++; $display("FAIL ram_addr t=%0t got %h exp %h", $time, ram_addr, ea); end
        if (ram_we !== ew) begin nerr++; $display("FAIL ram_we t=%0t got %b exp %b", $time, ram_we, ew); end
        if (ram_wdata !== ed) begin nerr++; $display("FAIL ram_wdata t=%0t got %h exp %h", $time, ram_wdata, ed); end
        if (rvalid !== m_rv) begin nerr++; $display("FAIL rvalid t=%0t got %b exp %b", $time, rvalid, m_rv); end
        if (frame_tick !== m_tick) begin nerr++; $display("FAIL frame_tick t=%0t got %b exp %b", $time, frame_tick, m_tick); end
        if (overrun !== m_over) begin nerr++; $display("FAIL overrun t=%0t got %b exp %b", $time, overrun, m_over); end
        ticks += int'(frame_tick);
        gnts  += int'(gnt != '0);
        wes   += int'(ram_we);
        @(negedge clk);
    endtask

    task automatic run_lines(input int n);
        for (int l = 0; l < n; l++) begin
            if (!rnd) ren_addr = AW'(l);
            VGA_enable = 1'b1;
            repeat (3) cyc();
            VGA_enable = 1'b0;
            cyc();
        end
    endtask

    task automatic vblank(input int pre, input int post);
        VGA_enable = 1'b0;
        repeat (pre) cyc();
        V_sync = 1'b0;
        repeat (2) cyc();
        V_sync = 1'b1;
        repeat (post) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '1; ren_addr = 8'h5A;
        @(negedge clk); @(negedge clk);
        #1;
        nvec += 6;
        if (gnt !== '0) begin nerr++; $display("FAIL reset_gnt got %b exp 0", gnt); end
        if (rvalid !== '0) begin nerr++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        if (frame_tick !== 1'b0) begin nerr++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        if (ram_we !== 1'b0) begin nerr++; $display("FAIL reset_we got %b exp 0", ram_we); end
        if (ram_addr !== 8'h5A) begin nerr++; $display("FAIL reset_addr got %h exp 5a", ram_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_idle_frame();
        ticks = 0; gnts = 0;
        run_lines(ACT);
        #1;
        nvec++;
        if (frame_tick !== 1'b1 || ticks != 0) begin
            nerr++; $display("FAIL idle_tick_timing got tick=%b prior=%0d exp tick=1 prior=0", frame_tick, ticks);
        end
        vblank(6, 3);
        nvec += 2;
        if (ticks != 1) begin nerr++; $display("FAIL idle_tick_count got %0d exp 1", ticks); end
        if (gnts != 0) begin nerr++; $display("FAIL idle_gnt_count got %0d exp 0", gnts); end
    endtask

    task automatic test_all_read();
        logic [N-1:0] exp_g, prev;
        req = '1; req_we = '0; req_addr = {8'd3, 8'd2, 8'd1, 8'd0};
        run_lines(ACT);
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            exp_g = N'(1) << (k % N);
            #1;
            nvec += 2;
            if (gnt !== exp_g) begin nerr++; $display("FAIL rr_seq k=%0d got %b exp %b", k, gnt, exp_g); end
            if (rvalid !== prev) begin nerr++; $display("FAIL rvalid_follow k=%0d got %b exp %b", k, rvalid, prev); end
            prev = exp_g;
            cyc();
        end
        req = '0;
        vblank(2, 3);
    endtask

    task automatic test_write_read();
        wes = 0;
        req = 4'b0100; req_we = 4'b0100;
        req_addr = '0; req_addr[2*AW +: AW] = 8'h10;
        req_wdata = '0; req_wdata[2*DW +: DW] = 16'hBEEF;
        run_lines(ACT);
        cyc();
        req = '0; req_we = '0;
        vblank(4, 3);
        nvec++;
        if (wes != 1) begin nerr++; $display("FAIL write_pulses got %0d exp 1", wes); end
        ren_addr = 8'h10; VGA_enable = 1'b1;
        cyc(); cyc();
        #1;
        nvec++;
        if (ram_rdata !== 16'hBEEF) begin nerr++; $display("FAIL render_read got %h exp beef", ram_rdata); end
        run_lines(ACT);
        vblank(4, 3);
    endtask

    task automatic test_overrun();
        req = 4'b0010; req_we = '0; req_addr = '0;
        run_lines(ACT);
        repeat (3) cyc();
        V_sync = 1'b0;
        repeat (2) cyc();
        V_sync = 1'b1;
        #1;
        nvec++;
        if (gnt !== '0) begin nerr++; $display("FAIL close_gnt got %b exp 0", gnt); end
        cyc();
        #1;
        nvec++;
        if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_set got %b exp 1", overrun); end
        req = '0;
        repeat (2) cyc();
        run_lines(ACT);
        vblank(4, 3);
        #1;
        nvec++;
        if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
    endtask

    task automatic test_early_enable();
        req = 4'b1000; req_we = '0;
        run_lines(ACT);
        cyc();
        VGA_enable = 1'b1;
        #1;
        nvec++;
        if (gnt !== '0) begin nerr++; $display("FAIL early_en_gnt got %b exp 0", gnt); end
        cyc();
        VGA_enable = 1'b0;
        #1;
        nvec++;
        if (gnt !== '0) begin nerr++; $display("FAIL early_en_state got %b exp 0", gnt); end
        cyc();
        req = '0;
        vblank(2, 3);
    endtask

    task automatic test_reset_mid_window();
        req = '1; req_we = 4'b0101; req_addr = $urandom;
        run_lines(ACT);
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1;
        nvec += 6;
        if (gnt !== '0) begin nerr++; $display("FAIL midrst_gnt got %b exp 0", gnt); end
        if (rvalid !== '0) begin nerr++; $display("FAIL midrst_rvalid got %b exp 0", rvalid); end
        if (frame_tick !== 1'b0) begin nerr++; $display("FAIL midrst_tick got %b exp 0", frame_tick); end
        if (overrun !== 1'b0) begin nerr++; $display("FAIL midrst_overrun got %b exp 0", overrun); end
        if (ram_we !== 1'b0) begin nerr++; $display("FAIL midrst_we got %b exp 0", ram_we); end
        if (ram_addr !== ren_addr) begin nerr++; $display("FAIL midrst_addr got %h exp %h", ram_addr, ren_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        gnts = 0; ticks = 0;
        repeat (5) cyc();
        nvec++;
        if (gnts != 0) begin nerr++; $display("FAIL midrst_no_gnt got %0d exp 0", gnts); end
        vblank(0, 3);
        req = '0; req_we = '0;
        nvec++;
        if (ticks != 1) begin nerr++; $display("FAIL midrst_tick_count got %0d exp 1", ticks); end
    endtask

    task automatic test_random();
        rnd = 1;
        for (int f = 0; f < 4; f++) begin
            run_lines($urandom_range(470, ACT));
            vblank($urandom_range(1, 10), $urandom_range(2, 6));
        end
        rnd = 0;
        req = '0; req_we = '0;
        repeat (3) cyc();
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_all_read();
        test_write_read();
        test_overrun();
        test_early_enable();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
